// File: rtl/paint_pkg.sv
`default_nettype none
// ============================================================================
// Module   : paint_pkg
// Brief    : Shared types and default constants for the paint colour
//            calibration path (state encoding, RGB pixel struct, window and
//            frame defaults, absolute-difference helper).
// Revision : 1.0 - initial release
// ============================================================================
package paint_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } calib_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int DEF_WIN_X0      = 312;
    localparam int DEF_WIN_Y0      = 232;
    localparam int DEF_LOG2_WIN    = 4;
    localparam int DEF_LOG2_FRAMES = 2;
    localparam int DEF_TOL         = 24;

    // |a - b| evaluated at 9-bit signed width so that 0 - 255 is representable
    function automatic logic [8:0] abs_diff9(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        logic signed [8:0] n;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        n = -d;
        return d[8] ? $unsigned(n) : $unsigned(d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : rgb_accumulator
// Brief    : Three independent per-channel running sums of an RGB stream,
//            with synchronous clear (priority) and add enable.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_accumulator
    import paint_pkg::*;
#(
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             add_en,
    input  rgb_t             pix_in,
    output logic [ACC_W-1:0] sum_r,
    output logic [ACC_W-1:0] sum_g,
    output logic [ACC_W-1:0] sum_b
);

    // Running sums; clear wins over add so a restart never inherits a pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else if (clear) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else if (add_en) begin
            sum_r <= sum_r + ACC_W'(pix_in.r);
            sum_g <= sum_g + ACC_W'(pix_in.g);
            sum_b <= sum_b + ACC_W'(pix_in.b);
        end
    end

endmodule
`default_nettype wire

// File: rtl/color_calibrator.sv
`default_nettype none
// ============================================================================
// Module   : color_calibrator
// Brief    : Averages the pixels of a square window at screen centre over
//            2^LOG2_FRAMES frames on a calibrate request, latches the result
//            as the reference paint colour and raises get_color.
//            Optional live colour-match output built when COLOR_MATCH_EN is
//            defined; otherwise pix_match is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module color_calibrator
    import paint_pkg::*;
#(
    parameter int WIN_X0      = DEF_WIN_X0,
    parameter int WIN_Y0      = DEF_WIN_Y0,
    parameter int LOG2_WIN    = DEF_LOG2_WIN,
    parameter int LOG2_FRAMES = DEF_LOG2_FRAMES,
    parameter int TOL         = DEF_TOL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic       busy,
    output logic       get_color,
    output logic [7:0] ref_r,
    output logic [7:0] ref_g,
    output logic [7:0] ref_b,
    output logic       pix_match
);

    // Average = sum >> SHIFT; the sum width guarantees no overflow
    localparam int SHIFT = 2 * LOG2_WIN + LOG2_FRAMES;
    localparam int ACC_W = 8 + SHIFT;
    localparam int FC_W  = (LOG2_FRAMES > 0) ? LOG2_FRAMES : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'((1 << LOG2_FRAMES) - 1);

    // Window bounds widened by one bit so the exclusive upper edge never wraps
    localparam logic [10:0] X_LO = 11'(WIN_X0);
    localparam logic [10:0] X_HI = 11'(WIN_X0 + (1 << LOG2_WIN));
    localparam logic [10:0] Y_LO = 11'(WIN_Y0);
    localparam logic [10:0] Y_HI = 11'(WIN_Y0 + (1 << LOG2_WIN));

    calib_state_t     state;
    calib_state_t     next_state;
    logic [FC_W-1:0]  frame_cnt;
    logic             in_win;
    logic             acc_clear;
    logic             acc_add;
    logic             frame_inc;
    logic             ref_load;
    rgb_t             pix_rgb;
    logic [ACC_W-1:0] sum_r;
    logic [ACC_W-1:0] sum_g;
    logic [ACC_W-1:0] sum_b;
    logic             unused_bits;

    assign in_win = ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI) &&
                    ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);

    assign pix_rgb = {pix_r, pix_g, pix_b};

    rgb_accumulator #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clear),
        .add_en (acc_add),
        .pix_in (pix_rgb),
        .sum_r  (sum_r),
        .sum_g  (sum_g),
        .sum_b  (sum_b)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and datapath control; the terminating frame_start's own pixel
    // belongs to the following frame and is therefore not summed
    always_comb begin
        next_state = state;
        acc_clear  = 1'b0;
        acc_add    = 1'b0;
        frame_inc  = 1'b0;
        ref_load   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ARM;
                    acc_clear  = 1'b1;
                end
            end
            ARM: begin
                if (frame_start) begin
                    next_state = ACCUM;
                    acc_add    = pix_valid & in_win;
                end
            end
            ACCUM: begin
                if (frame_start && (frame_cnt == FC_LAST)) begin
                    next_state = DONE;
                    ref_load   = 1'b1;
                end else begin
                    acc_add   = pix_valid & in_win;
                    frame_inc = frame_start;
                end
            end
            DONE: begin
                if (start) begin
                    next_state = ARM;
                    acc_clear  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Frame counter, restarted together with the accumulators
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          frame_cnt <= '0;
        else if (acc_clear) frame_cnt <= '0;
        else if (frame_inc) frame_cnt <= frame_cnt + 1'b1;
    end

    // Reference colour holds its old value until a new average is loaded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_r <= '0;
            ref_g <= '0;
            ref_b <= '0;
        end else if (ref_load) begin
            ref_r <= sum_r[ACC_W-1:SHIFT];
            ref_g <= sum_g[ACC_W-1:SHIFT];
            ref_b <= sum_b[ACC_W-1:SHIFT];
        end
    end

    assign busy      = (state == ARM) || (state == ACCUM);
    assign get_color = (state == DONE);

`ifdef COLOR_MATCH_EN
    localparam logic [8:0] TOL9 = 9'(TOL);

    logic match_next;

    assign match_next = get_color & pix_valid &
                        (abs_diff9(pix_r, ref_r) <= TOL9) &
                        (abs_diff9(pix_g, ref_g) <= TOL9) &
                        (abs_diff9(pix_b, ref_b) <= TOL9);

    // Live pixel match against the reference, one cycle behind the pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pix_match <= 1'b0;
        else       pix_match <= match_next;
    end

    // Fractional sum bits fall below the averaged reference
    assign unused_bits = ^{sum_r[SHIFT-1:0], sum_g[SHIFT-1:0], sum_b[SHIFT-1:0]};
`else
    assign pix_match = 1'b0;

    // Fractional sum bits and the tolerance have no consumer in this build
    assign unused_bits = (^{sum_r[SHIFT-1:0], sum_g[SHIFT-1:0], sum_b[SHIFT-1:0]}) ^
                         (TOL != 0);
`endif

endmodule
`default_nettype wire
